// File: rtl/rv_gpio_ctrl.sv
// Register-mapped GPIO block: synchronised and debounced inputs, output register
// with atomic set/clear, and sticky per-bit edge interrupts OR'd onto o_irq.
module rv_gpio_ctrl #(
  parameter int              WIDTH           = 16,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] OUT_RESET      = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [4:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_rvalid,
  output logic             o_irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    REG_IN      = 3'd0,
    REG_OUT     = 3'd1,
    REG_OUT_SET = 3'd2,
    REG_OUT_CLR = 3'd3,
    REG_RISE_EN = 3'd4,
    REG_FALL_EN = 3'd5,
    REG_STATUS  = 3'd6,
    REG_RSVD    = 3'd7
  } reg_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  reg_e             word;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] edge_set;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign word        = reg_e'(i_addr[4:2]);
  assign wdata       = i_wdata[WIDTH-1:0];
  assign unused_bits = ^{i_addr[1:0], i_wdata};

  always_comb begin
    sync_d[0] = i_gpio;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  // In bypass mode deb_q shadows the last sync stage so edge detection still
  // sees the debounced value change on the edge it happens.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i];
    if (DEBOUNCE_CYCLES == 0) begin
      deb_d = sync_d[SYNC_STAGES-1];
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            deb_d[i] = sync_q[SYNC_STAGES-1][i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    out_d      = out_q;
    rise_d     = rise_q;
    fall_d     = fall_q;
    status_clr = '0;
    if (i_we) begin
      case (word)
        REG_OUT:     out_d      = wdata;
        REG_OUT_SET: out_d      = out_q | wdata;
        REG_OUT_CLR: out_d      = out_q & ~wdata;
        REG_RISE_EN: rise_d     = wdata;
        REG_FALL_EN: fall_d     = wdata;
        REG_STATUS:  status_clr = wdata;
        default:     ;
      endcase
    end

    // Hardware set is OR'd after the W1C mask so a same-edge event is kept.
    edge_set = (deb_d & ~deb_q & rise_q) | (~deb_d & deb_q & fall_q);
    status_d = (status_q & ~status_clr) | edge_set;

    rd_word = '0;
    case (word)
      REG_IN:      rd_word[WIDTH-1:0] = deb_q;
      REG_OUT:     rd_word[WIDTH-1:0] = out_q;
      REG_RISE_EN: rd_word[WIDTH-1:0] = rise_q;
      REG_FALL_EN: rd_word[WIDTH-1:0] = fall_q;
      REG_STATUS:  rd_word[WIDTH-1:0] = status_q;
      default:     ;
    endcase
    rdata_d  = i_re ? rd_word : rdata_q;
    rvalid_d = i_re;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; the small arrays are reset like any flop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      deb_q    <= '0;
      out_q    <= OUT_RESET;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      deb_q    <= deb_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_gpio   = out_q;
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_irq    = |status_q;

endmodule

// File: tb/tb_rv_gpio_ctrl.sv
// Scoreboard bench for rv_gpio_ctrl: a debounced build (dut1) and a bypass build
// (dut2); read expectations are queued at issue and popped by a negedge monitor.
module tb_rv_gpio_ctrl;

  localparam logic [2:0] W_IN = 3'd0, W_OUT = 3'd1, W_SET = 3'd2, W_CLR = 3'd3;
  localparam logic [2:0] W_RISE = 3'd4, W_FALL = 3'd5, W_STAT = 3'd6, W_RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpio1, gpio2, gpo1, gpo2;
  logic        we1, re1, we2, re2;
  logic [4:0]  addr1, addr2;
  logic [31:0] wdata1, wdata2, rdata1, rdata2;
  logic        rvalid1, rvalid2, irq1, irq2;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_gpio_ctrl #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .OUT_RESET(16'h00A5)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_gpio(gpio1), .o_gpio(gpo1), .i_we(we1), .i_re(re1),
    .i_addr(addr1), .i_wdata(wdata1), .o_rdata(rdata1), .o_rvalid(rvalid1), .o_irq(irq1));

  rv_gpio_ctrl #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .OUT_RESET(16'h0000)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_gpio(gpio2), .o_gpio(gpo2), .i_we(we2), .i_re(re2),
    .i_addr(addr2), .i_wdata(wdata2), .o_rdata(rdata2), .o_rvalid(rvalid2), .o_irq(irq2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rvalid1_unexpected: got rvalid=1 expected no read pending");
      end else check("rdata1", rdata1, q1.pop_front());
    end
    if (rvalid2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL rvalid2_unexpected: got rvalid=1 expected no read pending");
      end else check("rdata2", rdata2, q2.pop_front());
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int d, input logic [2:0] w, input logic [31:0] v);
    if (d == 1) begin we1 = 1'b1; addr1 = {w, 2'b00}; wdata1 = v; end
    else        begin we2 = 1'b1; addr2 = {w, 2'b00}; wdata2 = v; end
    @(posedge clk); #1;
    we1 = 1'b0; we2 = 1'b0;
  endtask

  task automatic rd(input int d, input logic [2:0] w, input logic [31:0] exp);
    if (d == 1) begin re1 = 1'b1; addr1 = {w, 2'b11}; q1.push_back(exp); end
    else        begin re2 = 1'b1; addr2 = {w, 2'b11}; q2.push_back(exp); end
    @(posedge clk); #1;
    re1 = 1'b0; re2 = 1'b0;
  endtask

  // Reads issued on edges 1..7 after a pin change sample IN before each edge.
  task automatic in_ramp(input logic [31:0] final_val);
    for (int k = 1; k <= 7; k++) rd(1, W_IN, (k == 7) ? final_val : 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; gpio1 = 16'hFFFF; gpio2 = 16'h0000;
    we1 = 0; re1 = 0; addr1 = '0; wdata1 = '0;
    we2 = 0; re2 = 0; addr2 = '0; wdata2 = '0;
    idle(3);
    rst = 1'b0;
    check("reset_gpio", {16'h0, gpo1}, 32'h00A5);
    check("reset_irq", {31'h0, irq1}, 32'h0);
    in_ramp(32'hFFFF);
    rd(1, W_STAT, 32'h0);
    rd(1, W_OUT, 32'h00A5);
    gpio1 = 16'h0000;
    idle(10);
    rd(1, W_IN, 32'h0);

    // Output register and atomic set/clear
    wr(1, W_OUT, 32'h1234); check("out_write", {16'h0, gpo1}, 32'h1234);
    wr(1, W_SET, 32'h0F00); check("out_set", {16'h0, gpo1}, 32'h1F34);
    wr(1, W_CLR, 32'h0204); check("out_clr", {16'h0, gpo1}, 32'h1D30);
    rd(1, W_SET, 32'h0);
    rd(1, W_CLR, 32'h0);
    wr(1, W_OUT, 32'hABCD_1D30);
    rd(1, W_OUT, 32'h0000_1D30);
    rd(1, W_RSVD, 32'h0);

    // Glitch rejection then a real rising edge on bit 0
    wr(1, W_RISE, 32'h0001);
    rd(1, W_RISE, 32'h0001);
    gpio1 = 16'h0001; idle(3); gpio1 = 16'h0000; idle(10);
    rd(1, W_IN, 32'h0);
    rd(1, W_STAT, 32'h0);
    check("glitch_irq", {31'h0, irq1}, 32'h0);
    gpio1 = 16'h0001;
    for (int k = 1; k <= 7; k++) begin
      rd(1, W_IN, (k == 7) ? 32'h1 : 32'h0);
      check($sformatf("rise_irq_e%0d", k), {31'h0, irq1}, (k >= 6) ? 32'h1 : 32'h0);
    end
    rd(1, W_STAT, 32'h0001);

    // Falling edge on bit 15, W1C, and W1C colliding with a new fall
    gpio1 = 16'h8001; idle(10);
    wr(1, W_FALL, 32'h8000);
    wr(1, W_STAT, 32'h0001);
    check("w1c_bit0_irq", {31'h0, irq1}, 32'h0);
    gpio1 = 16'h0001; idle(5);
    check("fall_e5_irq", {31'h0, irq1}, 32'h0);
    idle(1);
    check("fall_e6_irq", {31'h0, irq1}, 32'h1);
    rd(1, W_STAT, 32'h8000);
    wr(1, W_STAT, 32'h8000);
    check("w1c_irq", {31'h0, irq1}, 32'h0);
    gpio1 = 16'h8001; idle(10);
    gpio1 = 16'h0001; idle(5);
    wr(1, W_STAT, 32'h8000);
    check("set_wins_irq", {31'h0, irq1}, 32'h1);
    rd(1, W_STAT, 32'h8000);

    // Read and W1C of STATUS on the same edge returns the old value
    wr(1, W_STAT, 32'h8000);
    wr(1, W_FALL, 32'h0001);
    wr(1, W_RISE, 32'h0002);
    gpio1 = 16'h0002; idle(8);
    check("status3_irq", {31'h0, irq1}, 32'h1);
    re1 = 1'b1; we1 = 1'b1; addr1 = {W_STAT, 2'b00}; wdata1 = 32'hFFFF;
    q1.push_back(32'h0003);
    @(posedge clk); #1;
    re1 = 1'b0; we1 = 1'b0;
    check("rw_clear_irq", {31'h0, irq1}, 32'h0);
    idle(2);
    check("rdata_hold", rdata1, 32'h0003);
    check("rvalid_low", {31'h0, rvalid1}, 32'h0);
    rd(1, W_STAT, 32'h0);

    // Reset with a debounce in progress and a read in flight
    gpio1 = 16'h0000; idle(3);
    rst = 1'b1; re1 = 1'b1; addr1 = {W_STAT, 2'b00};
    @(posedge clk); #1;
    re1 = 1'b0;
    check("rst_rvalid", {31'h0, rvalid1}, 32'h0);
    check("rst_gpio", {16'h0, gpo1}, 32'h00A5);
    check("rst_irq", {31'h0, irq1}, 32'h0);
    gpio1 = 16'h0004;
    idle(1);
    rst = 1'b0;
    in_ramp(32'h0004);
    rd(1, W_RISE, 32'h0);

    // Bypass build: IN follows the pin after the synchroniser only
    wr(2, W_RISE, 32'h0001);
    gpio2 = 16'h0001;
    rd(2, W_IN, 32'h0);
    check("byp_e1_irq", {31'h0, irq2}, 32'h0);
    rd(2, W_IN, 32'h0);
    check("byp_e2_irq", {31'h0, irq2}, 32'h1);
    rd(2, W_IN, 32'h1);

    idle(3);
    check("q1_drained", q1.size(), 32'h0);
    check("q2_drained", q2.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
